// File: rtl/fetch_ctrl_if.sv
// Fetch-control bus: PC/IF-ID control outputs plus hazard and redirect inputs.
// master is the fetch sequencer, slave is the datapath/pipeline side.
interface fetch_ctrl_if;
    logic [31:0] pc;
    logic        imem_ack;
    logic        load_use;
    logic        br_taken;
    logic [31:0] br_target;
    logic        exc;
    logic [31:0] npc;
    logic        pc_we;
    logic        ifid_we;
    logic        ifid_flush;
    logic        imem_req;
    logic [15:0] stall_cnt;

    modport master (
        input  pc, imem_ack, load_use, br_taken, br_target, exc,
        output npc, pc_we, ifid_we, ifid_flush, imem_req, stall_cnt
    );

    modport slave (
        output pc, imem_ack, load_use, br_taken, br_target, exc,
        input  npc, pc_we, ifid_we, ifid_flush, imem_req, stall_cnt
    );
endinterface

// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer: arbitrates sequential fetch, branch/exception redirect
// and load-use stall, and keeps a saturating fetch-stall cycle counter.
module fetch_ctrl #(
    parameter int unsigned BOOT_WAIT = 2,
    parameter logic [31:0] EXC_VEC   = 32'h0000_0004
) (
    input logic          clk,
    input logic          clr,
    fetch_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        StBoot     = 2'd0,
        StFetch    = 2'd1,
        StRedirect = 2'd2
    } state_e;

    localparam logic [4:0] BootWait = 5'(BOOT_WAIT);

    state_e      state_q, state_d;
    logic [3:0]  boot_cnt_q, boot_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic [31:0] npc;
    logic        pc_we;
    logic        ifid_we;
    logic        ifid_flush;
    logic        imem_req;
    logic [31:0] seq_pc;
    logic        boot_done;

    assign seq_pc    = bus.pc + 32'd4;
    // Widened so BOOT_WAIT=15 compares cleanly; BOOT_WAIT=0 leaves on the first clock.
    assign boot_done = ({1'b0, boot_cnt_q} + 5'd1) >= BootWait;

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        npc        = seq_pc;
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        ifid_flush = 1'b0;
        imem_req   = 1'b0;

        unique case (state_q)
            StBoot: begin
                ifid_flush = 1'b1;
                boot_cnt_d = boot_cnt_q + 4'd1;
                if (boot_done) state_d = StFetch;
            end
            StFetch: begin
                imem_req = 1'b1;
                if (bus.exc) begin
                    npc        = EXC_VEC;
                    pc_we      = 1'b1;
                    ifid_flush = 1'b1;
                    state_d    = StRedirect;
                end else if (bus.br_taken) begin
                    npc        = bus.br_target;
                    pc_we      = 1'b1;
                    ifid_flush = 1'b1;
                    state_d    = StRedirect;
                end else if (bus.load_use) begin
                    // IF/ID holds its instruction; neither write nor flush.
                    pc_we = 1'b0;
                end else if (bus.imem_ack) begin
                    pc_we   = 1'b1;
                    ifid_we = 1'b1;
                end else begin
                    ifid_flush = 1'b1;
                end
            end
            StRedirect: begin
                ifid_flush = 1'b1;
                if (bus.exc) begin
                    npc   = EXC_VEC;
                    pc_we = 1'b1;
                end else begin
                    state_d = StFetch;
                end
            end
            default: begin
                ifid_flush = 1'b1;
                state_d    = StBoot;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == StFetch && !pc_we && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= StBoot;
            boot_cnt_q  <= 4'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.npc        = npc;
    assign bus.pc_we      = pc_we;
    assign bus.ifid_we    = ifid_we;
    assign bus.ifid_flush = ifid_flush;
    assign bus.imem_req   = imem_req;
    assign bus.stall_cnt  = stall_cnt_q;

endmodule
